// File: rtl/spi_pkg.sv
// Shared types and elaboration-time helpers for the oversampled SPI target.
package spi_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } state_t;

    // Bits needed to count 0..value-1.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) r = i + 1;
        end
        return r;
    endfunction

    // The leading edge leaves the idle level, so it is a rising edge when idle is low.
    function automatic logic lead_is_rise(input logic cpol);
        return !cpol;
    endfunction

    function automatic logic sample_on_lead(input logic cpha);
        return !cpha;
    endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-flop synchroniser for one asynchronous pin with rise/fall strobes.
module spi_sync_edge
#(
    parameter int   STAGES    = 2,
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic i_d,
    output logic o_rise,
    output logic o_fall
);

    logic [STAGES-1:0] r_sync;
    logic              r_prev;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sync <= {STAGES{RESET_VAL}};
            r_prev <= RESET_VAL;
        end else begin
            r_sync <= {r_sync[STAGES-2:0], i_d};
            r_prev <= r_sync[STAGES-1];
        end
    end

    assign o_rise = r_sync[STAGES-1] & ~r_prev;
    assign o_fall = ~r_sync[STAGES-1] & r_prev;

endmodule

// File: rtl/spi_target_sync.sv
// SPI target clocked entirely by clk: pins are oversampled, edges become one-clk strobes.
// TX side: tx_valid/tx_ready fill a one-word holding register; a transfer happens when both are high.
module spi_target_sync
    import spi_pkg::*;
#(
    parameter int WIDTH       = 64,
    parameter bit CPOL        = 1'b0,
    parameter bit CPHA        = 1'b0,
    parameter bit MSB_FIRST   = 1'b1,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sclk,
    input  logic             cs_n,
    input  logic             mosi,
    output logic             miso,
    output logic             miso_oe,
    input  logic [WIDTH-1:0] tx_data,
    input  logic             tx_valid,
    output logic             tx_ready,
    output logic [WIDTH-1:0] rx_data,
    output logic             rx_valid,
    output logic             tx_underrun,
    output logic             frame_err,
    output logic             busy
);

    localparam int CNT_W       = clog2(WIDTH);
    localparam bit LEAD_RISE   = lead_is_rise(CPOL);
    localparam bit SAMPLE_LEAD = sample_on_lead(CPHA);

    logic w_sclk_rise, w_sclk_fall, w_cs_rise, w_cs_fall;
    logic w_lead, w_trail, w_sample_edge, w_shift_edge, w_mosi, w_accept;
    logic w_start, w_stop, w_shift_ev, w_sample_ev, w_load, w_word_done;
    logic [WIDTH-1:0] w_shreg_in_nxt;
    state_t r_state, w_state_nxt;

    logic [SYNC_STAGES-1:0] r_mosi_sync;
    logic [WIDTH-1:0]       r_shreg_in, r_shreg_out, r_hold, r_rx_data;
    logic [CNT_W-1:0]       r_bit_cnt;
    logic                   r_full, r_pending, r_rx_valid, r_underrun, r_frame_err;

    spi_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(CPOL)) u_sclk_sync (
        .clk    (clk),
        .rst    (rst),
        .i_d    (sclk),
        .o_rise (w_sclk_rise),
        .o_fall (w_sclk_fall)
    );

    spi_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_cs_sync (
        .clk    (clk),
        .rst    (rst),
        .i_d    (cs_n),
        .o_rise (w_cs_rise),
        .o_fall (w_cs_fall)
    );

    // mosi shares the sclk pipeline depth so its value lines up with the detected edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_mosi_sync <= '0;
        else      r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], mosi};
    end

    assign w_mosi        = r_mosi_sync[SYNC_STAGES-1];
    assign w_lead        = LEAD_RISE ? w_sclk_rise : w_sclk_fall;
    assign w_trail       = LEAD_RISE ? w_sclk_fall : w_sclk_rise;
    assign w_sample_edge = SAMPLE_LEAD ? w_lead : w_trail;
    assign w_shift_edge  = SAMPLE_LEAD ? w_trail : w_lead;
    assign w_accept      = tx_valid && !r_full;
    assign w_shreg_in_nxt = MSB_FIRST ? {r_shreg_in[WIDTH-2:0], w_mosi}
                                      : {w_mosi, r_shreg_in[WIDTH-1:1]};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= IDLE;
        else      r_state <= w_state_nxt;
    end

    // A CS edge owns its clk: any sclk edge coinciding with it is dropped.
    always_comb begin
        w_state_nxt = r_state;
        w_start     = 1'b0;
        w_stop      = 1'b0;
        w_shift_ev  = 1'b0;
        w_sample_ev = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_cs_fall) begin
                    w_state_nxt = ACTIVE;
                    w_start     = 1'b1;
                end
            end
            ACTIVE: begin
                if (w_cs_rise) begin
                    w_state_nxt = IDLE;
                    w_stop      = 1'b1;
                end else begin
                    w_shift_ev  = w_shift_edge;
                    w_sample_ev = w_sample_edge;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
        w_load      = (w_start && !CPHA) || (w_shift_ev && r_pending);
        w_word_done = w_sample_ev && (r_bit_cnt == CNT_W'(WIDTH - 1));
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_hold      <= '0;
            r_full      <= 1'b0;
            r_shreg_out <= '0;
            r_shreg_in  <= '0;
            r_bit_cnt   <= '0;
            r_pending   <= 1'b0;
            r_rx_data   <= '0;
            r_rx_valid  <= 1'b0;
            r_underrun  <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            r_rx_valid  <= 1'b0;
            r_underrun  <= 1'b0;
            r_frame_err <= 1'b0;

            // An accept and a load in one clk: the load sees empty, the new word stays held.
            if (w_accept)    r_full <= 1'b1;
            else if (w_load) r_full <= 1'b0;
            if (w_accept)    r_hold <= tx_data;

            if (w_load) begin
                r_shreg_out <= r_full ? r_hold : '0;
                r_underrun  <= !r_full;
            end else if (w_shift_ev) begin
                r_shreg_out <= MSB_FIRST ? {r_shreg_out[WIDTH-2:0], 1'b0}
                                         : {1'b0, r_shreg_out[WIDTH-1:1]};
            end

            if (w_start) begin
                r_bit_cnt  <= '0;
                r_shreg_in <= '0;
                r_pending  <= CPHA;
            end else if (w_stop) begin
                r_bit_cnt   <= '0;
                r_pending   <= 1'b0;
                r_frame_err <= (r_bit_cnt != '0);
            end else begin
                if (w_load) r_pending <= 1'b0;
                if (w_sample_ev) begin
                    r_shreg_in <= w_shreg_in_nxt;
                    if (w_word_done) begin
                        r_bit_cnt  <= '0;
                        r_rx_data  <= w_shreg_in_nxt;
                        r_rx_valid <= 1'b1;
                        r_pending  <= 1'b1;
                    end else begin
                        r_bit_cnt <= r_bit_cnt + CNT_W'(1);
                    end
                end
            end
        end
    end

    assign busy        = (r_state == ACTIVE);
    assign miso_oe     = busy;
    assign miso        = miso_oe & (MSB_FIRST ? r_shreg_out[WIDTH-1] : r_shreg_out[0]);
    assign tx_ready    = !r_full;
    assign rx_data     = r_rx_data;
    assign rx_valid    = r_rx_valid;
    assign tx_underrun = r_underrun;
    assign frame_err   = r_frame_err;

endmodule
